// File: rtl/abft_pkg.sv
// abft_pkg: shared FSM state type and default sizing for the ABFT checksum sequencer
package abft_pkg;
  localparam int ARRAY_SIZE = 4;
  localparam int ADDR_WIDTH = 3;
  localparam int Z_BITS = 12;
  typedef enum logic [2:0] {IDLE, LOAD, ACC, DRAIN, CHECK, CLEAR} state_t;
endpackage

// File: rtl/chk_cmp_n.sv
// chk_cmp_n: exact per-column equality check producing a mismatch mask
module chk_cmp_n #(
  parameter int n = 4,
  parameter int w = 12
) (
  input  logic [n*w-1:0] a,
  input  logic [n*w-1:0] b,
  output logic [n-1:0]   mis
);
  for (genvar i = 0; i < n; i++) begin : g_col
    assign mis[i] = a[i*w +: w] != b[i*w +: w];
  end
endmodule

// File: rtl/abft_seq_ctrl.sv
// abft_seq_ctrl: sequences load/accumulate/check/clear of an ABFT checksum array
module abft_seq_ctrl
  import abft_pkg::*;
#(
  parameter int arraySize    = ARRAY_SIZE,
  parameter int addressWidth = ADDR_WIDTH,
  parameter int zBits        = Z_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  input  logic [arraySize*zBits-1:0] acc_in,
  input  logic [arraySize*zBits-1:0] exp_in,
  output logic                       loading,
  output logic                       valid,
  output logic                       interrupt,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [arraySize-1:0]       err_col
);
  localparam logic [addressWidth-1:0] LAST = addressWidth'(arraySize - 1);
  state_t                     state_q, state_d;
  logic [addressWidth-1:0]    cnt_q, cnt_d;
  logic [arraySize*zBits-1:0] exp_q, exp_d;
  logic [arraySize-1:0]       err_col_q, err_col_d, mis;
  logic                       chk_q, chk_d;
  chk_cmp_n #(.n(arraySize), .w(zBits)) u_cmp (.a(acc_in), .b(exp_q), .mis(mis));
  // chk_q remembers that CLEAR was reached through CHECK, so done stays a pure state decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    err_col_d = err_col_q;
    chk_d     = state_q == CHECK;
    case (state_q)
      IDLE: if (start) begin
        state_d   = LOAD;
        cnt_d     = '0;
        exp_d     = exp_in;
        err_col_d = '0;
      end
      LOAD, ACC: begin
        cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        state_d = abort ? CLEAR : cnt_q != LAST ? state_q : state_q == LOAD ? ACC : DRAIN;
      end
      DRAIN: state_d = abort ? CLEAR : CHECK;
      CHECK: begin
        state_d   = CLEAR;
        err_col_d = mis;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      exp_q     <= '0;
      err_col_q <= '0;
      chk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      err_col_q <= err_col_d;
      chk_q     <= chk_d;
    end
  end
  assign loading   = state_q == LOAD;
  assign valid     = state_q == ACC;
  assign interrupt = state_q == CLEAR;
  assign busy      = state_q != IDLE;
  assign done      = state_q == CLEAR && chk_q;
  assign error     = |err_col_q;
  assign err_col   = err_col_q;
endmodule

// File: tb/tb_abft_seq_ctrl.sv
// tb_abft_seq_ctrl: directed vector table, hand sequences and randomized run against a phase-count model
module tb_abft_seq_ctrl;
  localparam int N = 4;
  localparam int Z = 12;
  localparam int A = 3;
  localparam logic [N*Z-1:0] E0    = {12'h3C1, 12'h0A5, 12'hFFF, 12'h001};
  localparam logic [N*Z-1:0] E_BAD = {12'h3C1, 12'h0A4, 12'hFFF, 12'h001};
  localparam logic [9:0] O_ID = 10'b0000000000;
  localparam logic [9:0] O_LD = 10'b1001000000;
  localparam logic [9:0] O_VA = 10'b0101000000;
  localparam logic [9:0] O_BS = 10'b0001000000;
  localparam logic [9:0] O_DN = 10'b0011100000;
  localparam logic [9:0] O_AB = 10'b0011000000;
  logic clk = 0, rst = 0, start = 0, abort = 0;
  logic [N*Z-1:0] acc_in = '0, exp_in = '0;
  logic loading, valid, interrupt, busy, done, error;
  logic [N-1:0] err_col;
  logic [9:0] outs;
  int checks = 0, errors = 0;
  typedef struct {logic s; logic a; logic b; logic [9:0] o;} vec_t;
  vec_t tbl[$];
  int ph;
  logic ab;
  logic [N*Z-1:0] m_exp;
  logic [N-1:0] m_err;
  abft_seq_ctrl #(.arraySize(N), .addressWidth(A), .zBits(Z)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .acc_in(acc_in), .exp_in(exp_in),
    .loading(loading), .valid(valid), .interrupt(interrupt), .busy(busy), .done(done),
    .error(error), .err_col(err_col)
  );
  assign outs = {loading, valid, interrupt, busy, done, error, err_col};
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask
  task automatic add(input logic s, input logic a, input logic b, input logic [9:0] o);
    tbl.push_back('{s, a, b, o});
  endtask
  task automatic run_table(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      chk($sformatf("vec%0d", k), int'(outs), int'(tbl[k].o));
      start  = tbl[k].s;
      abort  = tbl[k].a;
      acc_in = tbl[k].b ? E_BAD : E0;
      tick();
    end
    start = 0;
    abort = 0;
  endtask
  // Model tracks only the cycle offset within a pass; a pass is 2N+3 cycles long
  task automatic m_reset();
    ph = 0; ab = 0; m_exp = '0; m_err = '0;
  endtask
  function automatic logic [9:0] m_out();
    return {ph >= 1 && ph <= N, ph > N && ph <= 2*N, ph == 2*N+3, ph != 0,
            ph == 2*N+3 && !ab, |m_err, m_err};
  endfunction
  task automatic m_step(input logic s, input logic a, input logic [N*Z-1:0] e, input logic [N*Z-1:0] acc);
    if (ph == 0) begin
      if (s) begin ph = 1; m_exp = e; m_err = '0; ab = 0; end
    end else if (ph <= 2*N+1 && a) begin
      ph = 2*N+3; ab = 1;
    end else if (ph == 2*N+2) begin
      for (int c = 0; c < N; c++) m_err[c] = acc[c*Z +: Z] != m_exp[c*Z +: Z];
      ph++;
    end else if (ph == 2*N+3) ph = 0;
    else ph++;
  endtask
  initial begin
    int rises;
    logic prev;
    logic [63:0] r64;
    add(1, 0, 0, O_ID); repeat (4) add(0, 0, 0, O_LD); repeat (4) add(0, 0, 0, O_VA);
    add(0, 0, 0, O_BS); add(0, 0, 0, O_BS); add(0, 0, 0, O_DN); add(0, 0, 0, O_ID);
    add(1, 0, 0, O_ID); repeat (4) add(0, 0, 0, O_LD); repeat (4) add(0, 0, 0, O_VA);
    add(0, 0, 0, O_BS); add(0, 0, 1, O_BS); add(0, 0, 0, O_DN | 10'b0000010100);
    add(0, 0, 0, 10'b0000010100); add(1, 0, 0, 10'b0000010100);
    add(0, 0, 0, O_LD); add(0, 1, 0, O_LD); add(0, 0, 0, O_AB); add(0, 0, 0, O_ID);
    add(1, 0, 0, O_ID); repeat (4) add(0, 0, 0, O_LD); add(0, 0, 0, O_VA); add(0, 1, 0, O_VA);
    add(0, 0, 0, O_AB); add(0, 0, 0, O_ID);
    exp_in = E0;
    acc_in = E0;
    repeat (3) tick();
    chk("reset_outputs", int'(outs), 0);
    rst = 1;
    tick();
    run_table(0, 39);
    start = 1; tick(); start = 0; repeat (2) tick();
    chk("pre_reset_load", int'(outs), int'(O_LD));
    #3 rst = 0;
    #1 chk("async_reset", int'(outs), 0);
    tick();
    rst = 1;
    tick();
    run_table(0, 12);
    m_reset();
    rises = 0;
    prev = 0;
    start = 1;
    for (int k = 1; k <= 36; k++) begin
      m_step(start, abort, exp_in, acc_in);
      tick();
      chk($sformatf("held_start%0d", k), int'(outs), int'(m_out()));
      if (loading && !prev) rises++;
      prev = loading;
    end
    chk("held_start_rises", rises, 3);
    for (int k = 0; k < 3000; k++) begin
      start = $urandom_range(3) == 0;
      abort = $urandom_range(15) == 0;
      r64 = {$urandom(), $urandom()};
      exp_in = r64[N*Z-1:0];
      acc_in = m_exp;
      if ($urandom_range(1) == 1) acc_in[$urandom_range(N*Z-1)] ^= 1'b1;
      m_step(start, abort, exp_in, acc_in);
      tick();
      chk($sformatf("rand%0d", k), int'(outs), int'(m_out()));
      chk($sformatf("excl%0d", k), int'($onehot0({loading, valid, interrupt})), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/abft_seq_ctrl.md
ABFT_SEQ_CTRL -- requirements
Module: abft_seq_ctrl

Interface
REQ-001 SHALL have parameter arraySize, default 4: number of checksum columns and the length of each phase in cycles.
REQ-002 SHALL have parameter addressWidth, default 3: phase counter width; arraySize <= 2**addressWidth is required.
REQ-003 SHALL have parameter zBits, default 12: width of one accumulated checksum.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: request for one checksum pass; sampled only in IDLE.
REQ-007 SHALL have port abort, input, 1: cancel the pass in progress.
REQ-008 SHALL have port acc_in, input, arraySize*zBits: accumulator outputs, column 0 in the LSBs.
REQ-009 SHALL have port exp_in, input, arraySize*zBits: expected checksums, same packing as acc_in.
REQ-010 SHALL have port loading, output, 1: drives the accumulator array's load/shift phase.
REQ-011 SHALL have port valid, output, 1: drives the accumulator array's accumulate enable.
REQ-012 SHALL have port interrupt, output, 1: clears the accumulators and their internal counter.
REQ-013 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-014 SHALL have port done, output, 1: one-cycle pulse marking a completed, non-aborted pass.
REQ-015 SHALL have port error, output, 1: OR of err_col; held until the next accepted start.
REQ-016 SHALL have port err_col, output, arraySize: per-column mismatch mask; held until the next accepted start.

Function
REQ-017 SHALL implement a Moore FSM with states IDLE, LOAD, ACC, DRAIN, CHECK, CLEAR, and decode all control outputs from the registered state only.
REQ-018 In IDLE, start=1 SHALL move the FSM to LOAD, capture exp_in into an internal register, clear error and err_col, and reset the phase counter to 0.
REQ-019 LOAD SHALL assert loading for exactly arraySize cycles, counted 0..arraySize-1, then go to ACC with the counter reset to 0.
REQ-020 ACC SHALL assert valid for exactly arraySize cycles, then go to DRAIN.
REQ-021 DRAIN SHALL last one cycle with loading=0 and valid=0, to cover accumulator register latency, then go to CHECK.
REQ-022 CHECK SHALL last one cycle: compare each acc_in column against the captured expected value and register the mismatch mask.
REQ-023 CLEAR SHALL last one cycle: interrupt=1; done=1 only if entered from CHECK; error and err_col become visible in this cycle; then go to IDLE.
REQ-024 Timing for start sampled at cycle 0: loading in cycles 1..N, valid in N+1..2N, DRAIN in 2N+1, CHECK in 2N+2, CLEAR in 2N+3, IDLE in 2N+4, where N=arraySize.
REQ-025 start asserted outside IDLE SHALL be ignored, not queued.
REQ-026 abort=1 in LOAD, ACC or DRAIN SHALL force CLEAR on the next cycle: interrupt=1, done=0, error and err_col unchanged.
REQ-027 abort SHALL be ignored in IDLE, CHECK and CLEAR; start and abort together in IDLE SHALL accept the start.
REQ-028 loading, valid and interrupt SHALL be mutually exclusive in every cycle.
REQ-029 The comparison SHALL be exact over all zBits, with no masking or truncation.

Reset
REQ-030 rst=0 SHALL immediately force IDLE, counter=0, captured expected values=0, and loading, valid, interrupt, busy, done, error and err_col all =0.
REQ-031 Reset asserted mid-pass SHALL abandon the pass without issuing interrupt; after rst returns high, the first accepted start SHALL behave exactly as after power-up.

Structure
REQ-032 Shared package abft_pkg SHALL hold the FSM state enum typedef and the default values of arraySize, addressWidth and zBits.
REQ-033 The per-column comparator SHALL be one sub-module, chk_cmp_n (arraySize columns of zBits each, output is the mismatch mask), instantiated once.

Verification
REQ-034 N=4, start at cycle 0, acc_in equal to exp_in -> loading in cycles 1-4, valid in 5-8, done=1 and interrupt=1 at cycle 11, error=0, busy=0 from cycle 12.
REQ-035 exp_in column 2 = 12'h0A5 while acc_in column 2 = 12'h0A4 -> at cycle 11 done=1, err_col=4'b0100, error=1, both held until the next start.
REQ-036 abort at cycle 6 (in ACC) -> CLEAR at cycle 7 with interrupt=1 and done=0; IDLE at cycle 8; error unchanged.
REQ-037 start held high continuously -> a new pass is accepted only in IDLE cycles, i.e. every 2N+4=12 cycles; no overlap of loading, valid or interrupt.
REQ-038 rst driven low at cycle 3 (in LOAD) -> all outputs 0 immediately; a fresh start after release produces REQ-034 timing exactly.
